// File: rtl/bp_update_arbiter.sv
// Branch-predictor update arbiter: merges two branch-resolution ports into a
// circular FIFO and issues at most one predictor update per cycle.
`ifndef XLEN
`define XLEN 32
`endif

module bp_update_arbiter #(
    parameter int DEPTH = 4,
    parameter int XLEN  = `XLEN
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [1:0]                 in_valid,
    input  logic [1:0][XLEN-1:0]       in_pc,
    input  logic [1:0]                 in_direction,
    input  logic [1:0][XLEN-1:0]       in_target,
    output logic                       in_ready,
    input  logic                       squash,
    output logic                       update_EN,
    output logic [XLEN-1:0]            update_pc,
    output logic                       update_direction,
    output logic [XLEN-1:0]            update_target,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            direction;
        logic [XLEN-1:0] target;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   head, tail, slot1;
    logic [CW-1:0]   count_q, free, need1, enq;
    logic            deq, acc0, acc1, drop;
    entry_t          head_entry;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        deq   = (count_q != '0) && !squash;
        // Free space includes the slot the head vacates this same cycle.
        free  = CW'(DEPTH) - count_q + CW'(deq);
        need1 = in_valid[0] ? CW'(2) : CW'(1);
        acc0  = 1'b0;
        acc1  = 1'b0;
        drop  = 1'b0;
        if (!squash) begin
            if (in_valid[0]) begin
                if (free != '0) acc0 = 1'b1;
                else            drop = 1'b1;
            end
            if (in_valid[1]) begin
                if (free >= need1) acc1 = 1'b1;
                else               drop = 1'b1;
            end
        end
        enq   = CW'(acc0) + CW'(acc1);
        slot1 = acc0 ? tail + PW'(1) : tail;
    end

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else if (squash) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (deq) head <= head + PW'(1);
            tail     <= tail + PW'(enq);
            count_q  <= count_q - CW'(deq) + enq;
            overflow <= overflow | drop;
        end
    end

    // NOTE: entry storage is deliberately not reset; count gates every read.
    always_ff @(posedge clock) begin
        if (acc0) mem[tail]  <= '{pc: in_pc[0], direction: in_direction[0], target: in_target[0]};
        if (acc1) mem[slot1] <= '{pc: in_pc[1], direction: in_direction[1], target: in_target[1]};
    end

    always_comb begin
        head_entry       = mem[head];
        update_EN        = deq;
        update_pc        = update_EN ? head_entry.pc        : '0;
        update_direction = update_EN ? head_entry.direction : 1'b0;
        update_target    = update_EN ? head_entry.target    : '0;
    end

    assign count    = count_q;
    assign in_ready = (count_q <= CW'(DEPTH - 2));

endmodule
